// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, issues one outstanding imem request at a time,
// and hands fetched instructions to ID while honouring EX redirects and a response timeout.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_redirect_valid,
    input  logic [31:0] ex_redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        fetch_err
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {StBoot, StReq, StWait, StFlush, StHold} state_e;

    state_e            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       id_pc_q, id_pc_d;
    logic [31:0]       id_inst_q, id_inst_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [CntW-1:0]   cnt_inc;
    logic [31:0]       redir_pc;
    logic              redir;
    logic              unused_redir_bits;

    assign redir             = ex_redirect_valid;
    assign redir_pc          = {ex_redirect_pc[31:2], 2'b00};
    assign unused_redir_bits = ^ex_redirect_pc[1:0];
    assign cnt_inc           = (cnt_q == CntW'(TIMEOUT)) ? cnt_q : cnt_q + CntW'(1);

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        id_pc_d        = id_pc_q;
        id_inst_d      = id_inst_q;
        cnt_d          = cnt_q;
        err_d          = err_q;
        imem_req_valid = 1'b0;
        id_valid       = 1'b0;

        unique case (state_q)
            StBoot: begin
                if (redir) pc_d = redir_pc;
                state_d = StReq;
            end
            StReq: begin
                // Gated combinationally so a request never goes out to a PC about to be replaced.
                imem_req_valid = !redir;
                if (redir) begin
                    pc_d = redir_pc;
                end else if (imem_req_ready) begin
                    state_d = StWait;
                    cnt_d   = '0;
                end
            end
            StWait: begin
                if (imem_rsp_valid) begin
                    if (redir) begin
                        pc_d    = redir_pc;
                        state_d = StReq;
                    end else begin
                        id_inst_d = imem_rsp_data;
                        id_pc_d   = pc_q;
                        pc_d      = pc_q + 32'd4;
                        state_d   = StHold;
                    end
                end else begin
                    cnt_d = cnt_inc;
                    if (redir) begin
                        pc_d    = redir_pc;
                        state_d = StFlush;
                    end
                end
            end
            StFlush: begin
                // The killed response is still owed; swallow it before issuing to the new PC.
                if (redir) pc_d = redir_pc;
                if (imem_rsp_valid) begin
                    state_d = StReq;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StHold: begin
                id_valid = !redir;
                if (redir) begin
                    pc_d    = redir_pc;
                    state_d = StReq;
                end else if (id_ready) begin
                    state_d = StReq;
                end
            end
            default: state_d = StBoot;
        endcase

        if ((state_q == StWait || state_q == StFlush) && cnt_q == CntW'(TIMEOUT - 1)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StBoot;
            pc_q      <= RESET_PC;
            id_pc_q   <= RESET_PC;
            id_inst_q <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            id_pc_q   <= id_pc_d;
            id_inst_q <= id_inst_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    assign imem_req_addr = pc_q;
    assign id_pc         = id_pc_q;
    assign id_inst       = id_inst_q;
    assign fetch_err     = err_q;

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequences instruction fetch. Owns the architectural fetch PC and drives a single-outstanding request/response handshake to instruction memory.
- Hands the fetched PC and instruction to the ID stage over a valid/ready handshake.
- Applies EX-stage redirects (branch/jump) and discards any in-flight or held instruction they kill.
- Sits between the PC state and the IF/ID boundary, replacing the free-running PC+4 update with a stall- and redirect-aware sequencer.

Parameters:
- RESET_PC, 32'h8000_0000, fetch PC after reset.
- TIMEOUT, 64, cycles in WAIT or FLUSH without a response before fetch_err sets; minimum value 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- ex_redirect_valid  in  1  EX requests a PC change this cycle.
- ex_redirect_pc  in  32  redirect target; bits [1:0] are forced to 0.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  32  fetch address; always equals pc_q.
- imem_rsp_valid  in  1  response valid; exactly one response per accepted request, in order.
- imem_rsp_data  in  32  instruction word.
- id_valid  out  1  instruction available to ID.
- id_ready  in  1  ID accepts the instruction.
- id_pc  out  32  PC of the held instruction.
- id_inst  out  32  held instruction.
- fetch_err  out  1  sticky timeout flag.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=BOOT, pc_q=RESET_PC, id_pc=RESET_PC, id_inst=0, fetch_err=0, wait counter=0.
  - All valids are 0.
- States: BOOT, REQ, WAIT, FLUSH, HOLD. "redir" below means ex_redirect_valid=1.
- BOOT:
  - No request is issued.
  - Next cycle goes to REQ. A redirect here loads pc_q and still goes to REQ.
  - Result: the first request is issued on the 2nd edge after reset release.
- REQ:
  - imem_req_valid = !redir (combinational gating, so a request is never issued to a stale PC).
  - redir: pc_q <= target, stay in REQ.
  - Otherwise, on imem_req_ready: go to WAIT and clear the counter.
- WAIT (request accepted, response pending):
  - imem_rsp_valid && !redir: id_inst <= data, id_pc <= pc_q, pc_q <= pc_q+4, go to HOLD.
  - imem_rsp_valid && redir: drop the response, pc_q <= target, go to REQ.
  - !imem_rsp_valid && redir: pc_q <= target, go to FLUSH.
  - Otherwise the counter increments.
- FLUSH:
  - Waits for the killed response and discards it, then goes to REQ.
  - A further redirect in FLUSH only updates pc_q.
  - The counter keeps running across the WAIT→FLUSH transition.
- HOLD:
  - id_valid = !redir (combinational).
  - id_ready && !redir: transfer completes, go to REQ.
  - redir (regardless of id_ready): the instruction is killed (no transfer), pc_q <= target, go to REQ.
  - Instruction outputs stay stable while id_valid=1 && !id_ready.
- Timeout:
  - The counter saturates at TIMEOUT.
  - fetch_err sets when counter==TIMEOUT-1 while still in WAIT or FLUSH.
  - fetch_err clears only on reset.
  - The FSM keeps waiting; it is not aborted.
- PC arithmetic:
  - 32-bit, wraps modulo 2^32 (0xFFFF_FFFC+4 = 0).
  - pc_q[1:0] is always 00.
- imem_rsp_valid outside WAIT/FLUSH is ignored; it is a protocol violation, not checked.
- Reset asserted mid-transaction: immediate return to the reset values. Any in-flight memory response after reset release arrives in BOOT or REQ and is ignored.
- Throughput: non-overlapped. Minimum 3 cycles per instruction (REQ, WAIT, HOLD) with zero-latency ready and 1-cycle response.

Test Plan:
- Reset release, imem ready=1, 1-cycle response, id_ready=1:
  - req_addr sequence is 0x8000_0000, 0x8000_0004, 0x8000_0008.
  - id_pc matches each address, id_inst equals the returned data.
  - One id transfer every 3 cycles.
- id_ready=0 for 5 cycles in HOLD:
  - id_valid stays 1 and id_pc/id_inst are stable.
  - No new imem request is issued.
  - The transfer occurs on the cycle id_ready=1.
- Redirect to 0x8000_0103 while in WAIT:
  - The next response is discarded (id_valid stays 0).
  - The next request address is 0x8000_0100.
- Redirect in the same cycle as imem_rsp_valid, and redirect while in HOLD with id_ready=1:
  - No transfer occurs.
  - The next req_addr is the target.
- Redirect in REQ with imem_req_ready=1:
  - imem_req_valid=0 that cycle.
  - The next cycle requests the target.
- TIMEOUT=4, no response:
  - fetch_err=1 after the 4th cycle in WAIT.
  - It stays 1 after a late response.
  - Async reset mid-WAIT clears it and restarts at 0x8000_0000.
